// File: rtl/rr_merge_arbiter.sv
// Two-into-one round-robin stream merge with burst locking and a registered output stage.
// Optional RR_MERGE_SRC_TAG_EN adds a registered down_src tag (0=A, 1=B).
module rr_merge_arbiter #(
    parameter int unsigned D_WIDTH   = 6,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned C_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data_a,
    input  logic               up_valid_a,
    output logic               up_ready_a,
    input  logic [D_WIDTH-1:0] up_data_b,
    input  logic               up_valid_b,
    output logic               up_ready_b,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
`ifdef RR_MERGE_SRC_TAG_EN
    output logic               down_src,
`endif
    input  logic               down_ready
);

    localparam logic [C_WIDTH-1:0] BURST_MAX = C_WIDTH'(BURST_LEN);
    localparam logic [C_WIDTH-1:0] CNT_ONE   = C_WIDTH'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t             owner;
    logic [C_WIDTH-1:0] beat_cnt;
    logic               last_b;     // 1 when the most recent new owner was B

    logic load_en_c;
    logic grant_a_c;
    logic grant_b_c;
    logic xfer_a_c;
    logic xfer_b_c;

    // Grant: held lock first, then round-robin on contention, else whoever is valid.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (owner == OWN_A && up_valid_a && beat_cnt < BURST_MAX) begin
            grant_a_c = 1'b1;
        end else if (owner == OWN_B && up_valid_b && beat_cnt < BURST_MAX) begin
            grant_b_c = 1'b1;
        end else if (up_valid_a && up_valid_b) begin
            grant_a_c = last_b;
            grant_b_c = !last_b;
        end else begin
            grant_a_c = up_valid_a;
            grant_b_c = up_valid_b;
        end
    end

    assign load_en_c  = !down_valid | down_ready;
    assign up_ready_a = !rst & load_en_c & grant_a_c;
    assign up_ready_b = !rst & load_en_c & grant_b_c;
    assign xfer_a_c   = up_valid_a & up_ready_a;
    assign xfer_b_c   = up_valid_b & up_ready_b;

    // Output register plus ownership/beat-count state; all state moves only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
`ifdef RR_MERGE_SRC_TAG_EN
            down_src   <= 1'b0;
`endif
            owner      <= OWN_NONE;
            beat_cnt   <= '0;
            last_b     <= 1'b1;
        end else begin
            if (load_en_c) begin
                down_valid <= xfer_a_c | xfer_b_c;
                if (xfer_a_c) begin
                    down_data <= up_data_a;
`ifdef RR_MERGE_SRC_TAG_EN
                    down_src  <= 1'b0;
`endif
                end else if (xfer_b_c) begin
                    down_data <= up_data_b;
`ifdef RR_MERGE_SRC_TAG_EN
                    down_src  <= 1'b1;
`endif
                end
            end

            if (xfer_a_c) begin
                if (owner == OWN_A) begin
                    if (beat_cnt < BURST_MAX) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                    end
                end else begin
                    owner    <= OWN_A;
                    beat_cnt <= CNT_ONE;
                    last_b   <= 1'b0;
                end
            end else if (xfer_b_c) begin
                if (owner == OWN_B) begin
                    if (beat_cnt < BURST_MAX) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                    end
                end else begin
                    owner    <= OWN_B;
                    beat_cnt <= CNT_ONE;
                    last_b   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Self-checking bench for rr_merge_arbiter: vector table, directed sequences, random vs. reference model.
// Define RR_MERGE_SRC_TAG_EN for both files to also check down_src.
module tb_rr_merge_arbiter;

    localparam int unsigned DW = 6;
    localparam int unsigned BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] up_data_a = '0;
    logic          up_valid_a = 1'b0;
    logic          up_ready_a;
    logic [DW-1:0] up_data_b = '0;
    logic          up_valid_b = 1'b0;
    logic          up_ready_b;
    logic [DW-1:0] down_data;
    logic          down_valid;
    logic          down_ready = 1'b0;
`ifdef RR_MERGE_SRC_TAG_EN
    logic          down_src;
`endif

    rr_merge_arbiter #(.D_WIDTH(DW), .BURST_LEN(BL), .C_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data_a  (up_data_a),
        .up_valid_a (up_valid_a),
        .up_ready_a (up_ready_a),
        .up_data_b  (up_data_b),
        .up_valid_b (up_valid_b),
        .up_ready_b (up_ready_b),
        .down_data  (down_data),
        .down_valid (down_valid),
`ifdef RR_MERGE_SRC_TAG_EN
        .down_src   (down_src),
`endif
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    endtask

    task automatic chk_src(input int exp);
`ifdef RR_MERGE_SRC_TAG_EN
        chk("down_src", int'(down_src), exp);
`else
        if (exp < 0) $display("bad src expectation");
`endif
    endtask

    typedef struct {
        logic          va;
        logic [DW-1:0] da;
        logic          vb;
        logic [DW-1:0] db;
        logic          dr;
        logic          ra;
        logic          rb;
        logic          dv;
        logic [DW-1:0] dd;
        logic          src;
    } vec_t;

    function automatic vec_t mkv(input int va, input int da, input int vb, input int db, input int dr,
                                 input int ra, input int rb, input int dv, input int dd, input int src);
        vec_t v;
        v.va = 1'(va); v.da = DW'(da); v.vb = 1'(vb); v.db = DW'(db); v.dr = 1'(dr);
        v.ra = 1'(ra); v.rb = 1'(rb); v.dv = 1'(dv); v.dd = DW'(dd); v.src = 1'(src);
        return v;
    endfunction

    // Two cycles of reset with both requesters pushing; readies must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; up_valid_a = 1'b1; up_valid_b = 1'b1; down_ready = 1'b1;
        #1;
        chk("rst_ready_a", int'(up_ready_a), 0);
        chk("rst_ready_b", int'(up_ready_b), 0);
        @(negedge clk);
        #1;
        chk("rst_down_valid", int'(down_valid), 0);
        chk("rst_down_data", int'(down_data), 0);
        chk_src(0);
        @(negedge clk);
        rst = 1'b0; up_valid_a = 1'b0; up_valid_b = 1'b0;
    endtask

    // Reference model state (integers; owner 0=none 1=A 2=B, last 1=A 2=B).
    int m_dv, m_dd, m_src, m_owner, m_cnt, m_last;

    task automatic model_reset();
        m_dv = 0; m_dd = 0; m_src = 0; m_owner = 0; m_cnt = 0; m_last = 2;
    endtask

    function automatic int model_winner(input int va, input int vb);
        if (m_owner == 1 && va != 0 && m_cnt < int'(BL)) return 1;
        if (m_owner == 2 && vb != 0 && m_cnt < int'(BL)) return 2;
        if (va != 0 && vb != 0) return (m_last == 1) ? 2 : 1;
        if (va != 0) return 1;
        if (vb != 0) return 2;
        return 0;
    endfunction

    vec_t vecs[$];

    initial begin
        int k;
        int exp_d;
        int na;
        int nb;

        // ---- vector table: grant, backpressure hold, lock release, drain ----
        vecs.push_back(mkv(1, 5, 1, 33, 0,  1, 0, 0, 0,  0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(1, 6, 1, 33, 0,  0, 0, 1, 5,  0));
        vecs.push_back(mkv(1, 6, 1, 33, 1,  1, 0, 1, 5,  0));
        vecs.push_back(mkv(0, 7, 1, 33, 1,  0, 1, 1, 6,  0));
        vecs.push_back(mkv(1, 7, 1, 34, 1,  0, 1, 1, 33, 1));
        vecs.push_back(mkv(0, 7, 0, 34, 1,  0, 0, 1, 34, 1));
        vecs.push_back(mkv(0, 7, 0, 34, 0,  0, 0, 0, 34, 1));
        vecs.push_back(mkv(1, 7, 0, 34, 0,  1, 0, 0, 34, 1));
        vecs.push_back(mkv(0, 7, 0, 34, 1,  0, 0, 1, 7,  0));
        vecs.push_back(mkv(0, 7, 0, 34, 1,  0, 0, 0, 7,  0));

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            up_valid_a = vecs[i].va; up_data_a = vecs[i].da;
            up_valid_b = vecs[i].vb; up_data_b = vecs[i].db;
            down_ready = vecs[i].dr;
            #1;
            chk($sformatf("vec%0d_ready_a", i), int'(up_ready_a), int'(vecs[i].ra));
            chk($sformatf("vec%0d_ready_b", i), int'(up_ready_b), int'(vecs[i].rb));
            chk($sformatf("vec%0d_down_valid", i), int'(down_valid), int'(vecs[i].dv));
            chk($sformatf("vec%0d_down_data", i), int'(down_data), int'(vecs[i].dd));
            chk_src(int'(vecs[i].src));
        end

        // ---- A only: data 1..10 emerges on consecutive cycles ----
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            up_valid_a = (c < 10); up_data_a = DW'(c + 1);
            up_valid_b = 1'b0; down_ready = 1'b1;
            #1;
            chk("aonly_ready_b", int'(up_ready_b), 0);
            chk("aonly_ready_a", int'(up_ready_a), (c < 10) ? 1 : 0);
            chk("aonly_down_valid", int'(down_valid), (c >= 1 && c <= 10) ? 1 : 0);
            if (c >= 1 && c <= 10) chk("aonly_down_data", int'(down_data), c);
        end

        // ---- contention: blocks of BL beats alternating, A first ----
        do_reset();
        k = 0; na = 0; nb = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            up_valid_a = 1'b1; up_data_a = DW'(16 + na);
            up_valid_b = 1'b1; up_data_b = DW'(32 + nb);
            down_ready = 1'b1;
            #1;
            chk("cont_one_ready", int'(up_ready_a) + int'(up_ready_b), 1);
            if (c >= 1) begin
                exp_d = ((k / BL) % 2 == 0) ? 16 : 32;
                exp_d = exp_d + (k / (2 * BL)) * BL + (k % BL);
                chk("cont_down_valid", int'(down_valid), 1);
                chk($sformatf("cont_beat%0d", k), int'(down_data), exp_d);
                chk_src(((k / BL) % 2 == 0) ? 0 : 1);
                k++;
            end
            if (up_ready_a) na++;
            if (up_ready_b) nb++;
        end

        // ---- reset in the middle of an A burst ----
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            up_valid_a = 1'b1; up_data_a = DW'(40 + c); up_valid_b = 1'b0; down_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; up_valid_a = 1'b1; up_data_a = DW'(42); up_valid_b = 1'b1; up_data_b = DW'(50);
        #1;
        chk("midrst_down_valid_before", int'(down_valid), 1);
        chk("midrst_down_data_before", int'(down_data), 41);
        chk("midrst_ready_a", int'(up_ready_a), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_down_valid_after", int'(down_valid), 0);
        chk("midrst_down_data_after", int'(down_data), 0);
        chk("midrst_a_first", int'(up_ready_a), 1);
        chk("midrst_b_waits", int'(up_ready_b), 0);
        @(negedge clk);
        #1;
        chk("midrst_first_beat", int'(down_data), 42);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            int va, vb, da, db, dr, w, le;
            @(negedge clk);
            va = ($urandom_range(0, 3) != 0) ? 1 : 0;
            vb = ($urandom_range(0, 3) != 0) ? 1 : 0;
            dr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            da = int'($urandom_range(0, 63));
            db = int'($urandom_range(0, 63));
            up_valid_a = 1'(va); up_data_a = DW'(da);
            up_valid_b = 1'(vb); up_data_b = DW'(db);
            down_ready = 1'(dr);
            #1;
            w  = model_winner(va, vb);
            le = (m_dv == 0 || dr != 0) ? 1 : 0;
            chk("rnd_ready_a", int'(up_ready_a), (le != 0 && w == 1) ? 1 : 0);
            chk("rnd_ready_b", int'(up_ready_b), (le != 0 && w == 2) ? 1 : 0);
            chk("rnd_down_valid", int'(down_valid), m_dv);
            chk("rnd_down_data", int'(down_data), m_dd);
            chk_src(m_src);
            if (le != 0) begin
                m_dv = (w != 0) ? 1 : 0;
                if (w == 1) begin m_dd = da; m_src = 0; end
                if (w == 2) begin m_dd = db; m_src = 1; end
                if (w != 0) begin
                    if (m_owner == w) m_cnt = (m_cnt < int'(BL)) ? m_cnt + 1 : m_cnt;
                    else begin m_owner = w; m_cnt = 1; m_last = w; end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
